dsm_sequencer: RTL

DSM_SEQUENCER -- requirements
Module: dsm_sequencer

---
 rtl/dsm_sequencer_pkg.sv | 30 +++
 rtl/dsm_dither_lfsr.sv | 35 +++
 rtl/dsm_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/dsm_sequencer_pkg.sv
// Shared definitions for the delta-sigma modulator sequencer.
// Holds the sample width, FSM state encoding, pwm code constants and
// the dither LFSR seed/tap mask.
package dsm_sequencer_pkg;

    localparam int unsigned T_BITS = 16;
    localparam int unsigned LFSR_W = 16;

    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: feedback is
    // the parity of bits 0, 2, 3 and 5, shifted in at bit 15.
    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

    localparam logic [1:0] PWM_ZERO = 2'b00;
    localparam logic [1:0] PWM_POS  = 2'b01;
    localparam logic [1:0] PWM_NEG  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_RUN  = 2'd2,
        ST_MUTE = 2'd3
    } state_t;

    // True in the states where the modulator is released and running.
    function automatic logic is_active(input state_t s);
        return (s == ST_RAMP) || (s == ST_RUN);
    endfunction

endpackage

// File: rtl/dsm_dither_lfsr.sv
// Dither source: 16-bit Fibonacci LFSR, advanced on every clock that
// 'advance' is high, with its low DITH_BITS bits sign-extended to T_BITS.
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   advance        step the LFSR this clock
//   dith_c         sign-extended low bits of the current LFSR state
module dsm_dither_lfsr
    import dsm_sequencer_pkg::*;
#(
    parameter int unsigned DITH_BITS = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              advance,
    output logic [T_BITS-1:0] dith_c
);

    logic [LFSR_W-1:0] lfsr_q;
    logic              feedback;
    logic signed [DITH_BITS-1:0] dith_raw;

    assign feedback = ^(lfsr_q & LFSR_TAPS);
    assign dith_raw = $signed(lfsr_q[DITH_BITS-1:0]);
    assign dith_c   = T_BITS'(dith_raw);

    // LFSR state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else if (advance) begin
            lfsr_q <= {feedback, lfsr_q[LFSR_W-1:1]};
        end
    end

endmodule

// File: rtl/dsm_sequencer.sv
// Sequencer for a delta-sigma modulator: buffers one input sample per
// frame of OSR clocks, soft-starts the drive with a shift ramp, watches
// the modulator output for overload and mutes it, and supplies dither.
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   enable, dith_en     run request, dither enable (levels)
//   in_data/valid/ready sample input handshake
//   pwm                 modulator output code (00 zero, 01 +, 11 -)
//   vin, dith_o         signed drive and dither to the modulator
//   dsm_rst             hold-reset to the modulator
//   frame_strobe        last cycle of each frame
//   underrun            sticky: a frame started with no pending sample
//   overload            one-cycle pulse on overload detection
//   state_o             current FSM state
module dsm_sequencer
    import dsm_sequencer_pkg::*;
#(
    parameter int unsigned OSR       = 64,
    parameter int unsigned RAMP_SH   = 4,
    parameter int unsigned OVL_LIMIT = 32,
    parameter int unsigned MUTE_CYC  = 256,
    parameter int unsigned DITH_BITS = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              dith_en,
    input  logic [T_BITS-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        pwm,
    output logic [T_BITS-1:0] vin,
    output logic [T_BITS-1:0] dith_o,
    output logic              dsm_rst,
    output logic              frame_strobe,
    output logic              underrun,
    output logic              overload,
    output logic [1:0]        state_o
);

    localparam int unsigned CNT_W  = (OSR > 2) ? $clog2(OSR) : 1;
    localparam int unsigned SH_W   = $clog2(T_BITS) + 1;
    localparam int unsigned OVL_W  = (OVL_LIMIT > 2) ? $clog2(OVL_LIMIT) : 1;
    localparam int unsigned MUTE_W = (MUTE_CYC > 2) ? $clog2(MUTE_CYC) : 1;

    state_t            state_q;
    state_t            state_n;
    logic [CNT_W-1:0]  cnt_q;
    logic [SH_W-1:0]   shift_q;
    logic              pend_full_q;
    logic [T_BITS-1:0] pend_q;
    logic [T_BITS-1:0] cur_q;
    logic [OVL_W-1:0]  ovl_cnt_q;
    logic [1:0]        pwm_prev_q;
    logic [MUTE_W-1:0] mute_cnt_q;
    logic [T_BITS-1:0] dith_c;

    logic active;
    logic handshake;
    logic pwm_match;
    logic ovl_hit;
    logic mute_done;
    logic ramp_done;
    logic load_idle;
    logic enter_ramp;

    // Decodes from registers.
    assign active       = is_active(state_q);
    assign frame_strobe = active && (cnt_q == CNT_W'(OSR - 1));
    assign in_ready     = !pend_full_q || frame_strobe;
    assign handshake    = in_valid && in_ready;
    assign state_o      = state_q;

    // An overload run is a repeated non-zero code; 10 is not a legal code.
    assign pwm_match = (pwm == pwm_prev_q) && ((pwm == PWM_POS) || (pwm == PWM_NEG));
    // Fires on the match that takes the counter to OVL_LIMIT-1.
    assign ovl_hit   = active && pwm_match && (ovl_cnt_q == OVL_W'(OVL_LIMIT - 2));
    assign mute_done = (mute_cnt_q == MUTE_W'(MUTE_CYC - 1));
    assign ramp_done = (shift_q == '0);

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next state; enable low wins over overload and frame events.
    always_comb begin
        state_n    = state_q;
        load_idle  = 1'b0;
        enter_ramp = 1'b0;
        if (!enable) begin
            state_n = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_n   = ST_RAMP;
                    load_idle = 1'b1;
                end
                ST_RAMP: begin
                    if (ovl_hit) begin
                        state_n = ST_MUTE;
                    end else if (frame_strobe && ramp_done) begin
                        state_n = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (ovl_hit) begin
                        state_n = ST_MUTE;
                    end
                end
                ST_MUTE: begin
                    if (mute_done) begin
                        state_n = ST_RAMP;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
        enter_ramp = (state_n == ST_RAMP) && (state_q != ST_RAMP);
    end

    // Frame counter: free-runs only while staying in RAMP/RUN.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (active && is_active(state_n)) begin
            cnt_q <= frame_strobe ? '0 : cnt_q + CNT_W'(1);
        end else begin
            cnt_q <= '0;
        end
    end

    // Ramp attenuation: reloaded on every entry to RAMP, one step per frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            shift_q <= SH_W'(RAMP_SH);
        end else if (enter_ramp) begin
            shift_q <= SH_W'(RAMP_SH);
        end else if ((state_q == ST_RAMP) && frame_strobe && !ramp_done) begin
            shift_q <= shift_q - SH_W'(1);
        end
    end

    // Pending/current sample holding path; later writes take precedence.
    always_ff @(posedge clock) begin
        if (reset) begin
            pend_full_q <= 1'b0;
            pend_q      <= '0;
            cur_q       <= '0;
            underrun    <= 1'b0;
        end else begin
            if (frame_strobe) begin
                if (pend_full_q) begin
                    cur_q <= pend_q;
                end else begin
                    underrun <= 1'b1;
                end
                pend_full_q <= 1'b0;
            end
            if (load_idle) begin
                cur_q       <= pend_q;
                pend_full_q <= 1'b0;
            end
            if (handshake) begin
                pend_q      <= in_data;
                pend_full_q <= 1'b1;
            end
        end
    end

    // Overload run-length detector, idle outside RAMP/RUN.
    always_ff @(posedge clock) begin
        if (reset) begin
            ovl_cnt_q  <= '0;
            pwm_prev_q <= PWM_ZERO;
            overload   <= 1'b0;
        end else begin
            pwm_prev_q <= active ? pwm : PWM_ZERO;
            if (!active || ovl_hit || !pwm_match) begin
                ovl_cnt_q <= '0;
            end else begin
                ovl_cnt_q <= ovl_cnt_q + OVL_W'(1);
            end
            overload <= ovl_hit && enable;
        end
    end

    // Mute dwell counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            mute_cnt_q <= '0;
        end else if (state_q == ST_MUTE) begin
            mute_cnt_q <= mute_cnt_q + MUTE_W'(1);
        end else begin
            mute_cnt_q <= '0;
        end
    end

    // Modulator drive. vin follows the registered state/current one clock
    // later; dsm_rst and dith_o are aligned with the state they belong to.
    always_ff @(posedge clock) begin
        if (reset) begin
            vin     <= '0;
            dsm_rst <= 1'b1;
            dith_o  <= '0;
        end else begin
            case (state_q)
                ST_RAMP: vin <= T_BITS'($signed(cur_q) >>> shift_q);
                ST_RUN:  vin <= cur_q;
                default: vin <= '0;
            endcase
            dsm_rst <= !is_active(state_n);
            dith_o  <= (dith_en && is_active(state_n)) ? dith_c : '0;
        end
    end

    dsm_dither_lfsr #(
        .DITH_BITS (DITH_BITS)
    ) u_dither (
        .clock   (clock),
        .reset   (reset),
        .advance (dith_en),
        .dith_c  (dith_c)
    );

endmodule
